// File: rtl/tlul_host_arb.sv
// tlul_host_arb: round-robin N:1 TL-UL host arbiter with in-order D-channel routing FIFO.
// Define TLUL_HOST_ARB_PRIO_EN to give host 0 strict priority over the round-robin hosts.
package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_host_arb #(
    parameter int NumHosts = 3,
    parameter int MaxOutstanding = 4,
    localparam int IdxW = (NumHosts > 2) ? $clog2(NumHosts) : 1,
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
    localparam int CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tlul_pkg::tl_h2d_t  tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t  tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t  tl_d_o,
    input  tlul_pkg::tl_d2h_t  tl_d_i,
    output logic               err_o,
    output logic [CntW-1:0]    outstanding_o
);
    logic [NumHosts-1:0] req;
    logic [IdxW-1:0]     ptr, arb, idx, gnt, hold_idx, head;
    logic [IdxW-1:0]     fifo [MaxOutstanding];
    logic [PtrW-1:0]     wptr, rptr;
    logic                hold, found, full, empty, push, pop;

    always_comb begin
        for (int i = 0; i < NumHosts; i++) req[i] = tl_h_i[i].a_valid;
    end

    always_comb begin
        arb   = ptr;
        idx   = '0;
        found = 1'b0;
`ifdef TLUL_HOST_ARB_PRIO_EN
        if (req[0]) begin
            arb   = '0;
            found = 1'b1;
        end
`endif
        for (int i = 0; i < NumHosts; i++) begin
            idx = IdxW'((int'(ptr) + i) % NumHosts);
            if (!found && req[idx]) begin
                arb   = idx;
                found = 1'b1;
            end
        end
    end

    // A request already offered to the device keeps its grant until accepted.
    assign gnt   = (hold && req[hold_idx]) ? hold_idx : arb;
    assign head  = fifo[rptr];
    assign full  = outstanding_o == CntW'(MaxOutstanding);
    assign empty = outstanding_o == '0;

    always_comb begin
        tl_d_o         = tl_h_i[gnt];
        tl_d_o.a_valid = req[gnt] && !full && !rst_i;
        tl_d_o.d_ready = empty || tl_h_i[head].d_ready;
    end

    assign push = tl_d_o.a_valid && tl_d_i.a_ready;
    assign pop  = tl_d_i.d_valid && tl_d_o.d_ready && !empty;

    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]         = tl_d_i;
            tl_h_o[i].a_ready = push && gnt == IdxW'(i);
            tl_h_o[i].d_valid = tl_d_i.d_valid && !empty && !rst_i && head == IdxW'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo[wptr] <= gnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr           <= '0;
            hold          <= 1'b0;
            hold_idx      <= '0;
            wptr          <= '0;
            rptr          <= '0;
            outstanding_o <= '0;
            err_o         <= 1'b0;
        end else begin
            if (push) begin
                wptr <= (wptr == PtrW'(MaxOutstanding - 1)) ? '0 : wptr + 1'b1;
                ptr  <= (gnt == IdxW'(NumHosts - 1)) ? '0 : gnt + 1'b1;
            end
            if (pop) rptr <= (rptr == PtrW'(MaxOutstanding - 1)) ? '0 : rptr + 1'b1;
            outstanding_o <= outstanding_o + CntW'(push) - CntW'(pop);
            err_o         <= err_o || (tl_d_i.d_valid && empty);
            hold          <= tl_d_o.a_valid && !tl_d_i.a_ready;
            hold_idx      <= gnt;
        end
    end
endmodule

// File: tb/tb_tlul_host_arb.sv
// tb_tlul_host_arb: directed self-checking bench for tlul_host_arb (3 hosts, 4 outstanding).
module tb_tlul_host_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    tlul_pkg::tl_h2d_t h_i [3];
    tlul_pkg::tl_d2h_t h_o [3];
    tlul_pkg::tl_h2d_t d_o;
    tlul_pkg::tl_d2h_t d_i;
    logic       err;
    logic [2:0] outs;
    int checks = 0;
    int failures = 0;

    tlul_host_arb #(.NumHosts(3), .MaxOutstanding(4)) dut (
        .clk_i(clk), .rst_i(rst), .tl_h_i(h_i), .tl_h_o(h_o),
        .tl_d_o(d_o), .tl_d_i(d_i), .err_o(err), .outstanding_o(outs)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ar();
        return {h_o[2].a_ready, h_o[1].a_ready, h_o[0].a_ready};
    endfunction

    function automatic logic [2:0] dv();
        return {h_o[2].d_valid, h_o[1].d_valid, h_o[0].d_valid};
    endfunction

    task automatic drive(input logic [2:0] av, input logic [2:0] dr, input logic dev_ar, input logic dev_dv);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            h_i[i].a_valid = av[i];
            h_i[i].d_ready = dr[i];
        end
        d_i.a_ready = dev_ar;
        d_i.d_valid = dev_dv;
        #1;
    endtask

    task automatic test_reset();
        drive(3'b111, 3'b111, 1'b1, 1'b1);
        checks++; if (d_o.a_valid !== 1'b0) begin failures++; $display("FAIL rst_a_valid got=%b exp=0", d_o.a_valid); end
        checks++; if (ar() !== 3'b000) begin failures++; $display("FAIL rst_a_ready got=%b exp=000", ar()); end
        checks++; if (dv() !== 3'b000) begin failures++; $display("FAIL rst_d_valid got=%b exp=000", dv()); end
        checks++; if (outs !== 3'd0) begin failures++; $display("FAIL rst_outstanding got=%0d exp=0", outs); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 6; k++) begin
            drive(3'b111, 3'b111, 1'b1, k > 0);
            checks++; if (ar() !== 3'(1 << (k % 3))) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, ar(), 3'(1 << (k % 3))); end
            checks++; if (d_o.a_source !== 8'(16 + k % 3)) begin failures++; $display("FAIL rr_source k=%0d got=%0h exp=%0h", k, d_o.a_source, 8'(16 + k % 3)); end
            if (k > 0) begin
                checks++; if (dv() !== 3'(1 << ((k - 1) % 3))) begin failures++; $display("FAIL rr_route k=%0d got=%b exp=%b", k, dv(), 3'(1 << ((k - 1) % 3))); end
                checks++; if (h_o[(k - 1) % 3].d_data !== 32'h1234_5678) begin failures++; $display("FAIL rr_d_data k=%0d got=%h exp=12345678", k, h_o[(k - 1) % 3].d_data); end
                checks++; if (outs !== 3'd1) begin failures++; $display("FAIL rr_outstanding k=%0d got=%0d exp=1", k, outs); end
            end else begin
                checks++; if (dv() !== 3'b000) begin failures++; $display("FAIL rr_route0 got=%b exp=000", dv()); end
            end
        end
        drive(3'b000, 3'b111, 1'b1, 1'b1);
        checks++; if (d_o.a_valid !== 1'b0) begin failures++; $display("FAIL rr_idle_a_valid got=%b exp=0", d_o.a_valid); end
        checks++; if (dv() !== 3'b100) begin failures++; $display("FAIL rr_last_route got=%b exp=100", dv()); end
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        checks++; if (outs !== 3'd0) begin failures++; $display("FAIL rr_drained got=%0d exp=0", outs); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rr_err got=%b exp=0", err); end
    endtask

    task automatic test_full();
        logic [2:0] heads [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
        for (int k = 0; k < 4; k++) begin
            drive(3'b111, 3'b111, 1'b1, 1'b0);
            checks++; if (ar() !== 3'(1 << (k % 3))) begin failures++; $display("FAIL full_fill k=%0d got=%b exp=%b", k, ar(), 3'(1 << (k % 3))); end
        end
        drive(3'b111, 3'b111, 1'b1, 1'b1);
        checks++; if (outs !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", outs); end
        checks++; if (d_o.a_valid !== 1'b0) begin failures++; $display("FAIL full_a_valid got=%b exp=0", d_o.a_valid); end
        checks++; if (ar() !== 3'b000) begin failures++; $display("FAIL full_a_ready got=%b exp=000", ar()); end
        checks++; if (dv() !== 3'b001) begin failures++; $display("FAIL full_route got=%b exp=001", dv()); end
        drive(3'b111, 3'b111, 1'b1, 1'b0);
        checks++; if (outs !== 3'd3) begin failures++; $display("FAIL full_after_pop got=%0d exp=3", outs); end
        checks++; if (ar() !== 3'b010) begin failures++; $display("FAIL full_regrant got=%b exp=010", ar()); end
        drive(3'b000, 3'b101, 1'b0, 1'b1);
        checks++; if (d_o.d_ready !== 1'b0) begin failures++; $display("FAIL full_d_ready_bp got=%b exp=0", d_o.d_ready); end
        checks++; if (dv() !== 3'b010) begin failures++; $display("FAIL full_bp_route got=%b exp=010", dv()); end
        for (int k = 0; k < 4; k++) begin
            drive(3'b000, 3'b111, 1'b0, 1'b1);
            checks++; if (outs !== 3'(4 - k)) begin failures++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, outs, 4 - k); end
            checks++; if (dv() !== heads[k]) begin failures++; $display("FAIL drain_route k=%0d got=%b exp=%b", k, dv(), heads[k]); end
        end
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        checks++; if (outs !== 3'd0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", outs); end
    endtask

    task automatic test_hold();
        drive(3'b010, 3'b111, 1'b0, 1'b0);
        checks++; if (d_o.a_valid !== 1'b1 || d_o.a_source !== 8'h11) begin failures++; $display("FAIL hold_offer got=%b/%0h exp=1/11", d_o.a_valid, d_o.a_source); end
        checks++; if (ar() !== 3'b000) begin failures++; $display("FAIL hold_no_ready got=%b exp=000", ar()); end
        drive(3'b110, 3'b111, 1'b0, 1'b0);
        checks++; if (d_o.a_source !== 8'h11) begin failures++; $display("FAIL hold_keep got=%0h exp=11", d_o.a_source); end
        drive(3'b110, 3'b111, 1'b1, 1'b0);
        checks++; if (ar() !== 3'b010) begin failures++; $display("FAIL hold_accept got=%b exp=010", ar()); end
        drive(3'b110, 3'b111, 1'b1, 1'b0);
        checks++; if (ar() !== 3'b100 || d_o.a_source !== 8'h12) begin failures++; $display("FAIL hold_next got=%b/%0h exp=100/12", ar(), d_o.a_source); end
    endtask

    task automatic test_reset_mid();
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        checks++; if (outs !== 3'd2) begin failures++; $display("FAIL mid_pre_count got=%0d exp=2", outs); end
        #2;
        for (int i = 0; i < 3; i++) h_i[i].a_valid = 1'b1;
        d_i.a_ready = 1'b1;
        d_i.d_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (outs !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", outs); end
        checks++; if (d_o.a_valid !== 1'b0 || ar() !== 3'b000 || dv() !== 3'b000) begin failures++; $display("FAIL mid_outputs got=%b/%b/%b exp=0/000/000", d_o.a_valid, ar(), dv()); end
        @(negedge clk);
        rst = 1'b0;
        d_i.a_ready = 1'b0;
        d_i.d_valid = 1'b0;
        #1;
        checks++; if (d_o.a_valid !== 1'b1 || d_o.a_source !== 8'h10) begin failures++; $display("FAIL mid_restart got=%b/%0h exp=1/10", d_o.a_valid, d_o.a_source); end
        drive(3'b000, 3'b111, 1'b0, 1'b0);
    endtask

    task automatic test_err();
        drive(3'b000, 3'b111, 1'b0, 1'b1);
        checks++; if (d_o.d_ready !== 1'b1) begin failures++; $display("FAIL err_d_ready got=%b exp=1", d_o.d_ready); end
        checks++; if (dv() !== 3'b000) begin failures++; $display("FAIL err_no_route got=%b exp=000", dv()); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", err); end
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        checks++; if (err !== 1'b1 || outs !== 3'd0) begin failures++; $display("FAIL err_set got=%b/%0d exp=1/0", err, outs); end
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err); end
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_prio();
        logic [1:0] g;
        logic [1:0] prev;
        prev = 2'd0;
        for (int k = 0; k < 5; k++) begin
`ifdef TLUL_HOST_ARB_PRIO_EN
            g = 2'd0;
`else
            g = (k % 2 == 1) ? 2'd2 : 2'd0;
`endif
            drive(3'b101, 3'b111, 1'b1, k > 0);
            checks++; if (ar() !== 3'(1 << g) || d_o.a_source !== 8'(16 + g)) begin failures++; $display("FAIL prio_grant k=%0d got=%b/%0h exp=%b/%0h", k, ar(), d_o.a_source, 3'(1 << g), 8'(16 + g)); end
            if (k > 0) begin
                checks++; if (dv() !== 3'(1 << prev)) begin failures++; $display("FAIL prio_route k=%0d got=%b exp=%b", k, dv(), 3'(1 << prev)); end
            end
            prev = g;
        end
        drive(3'b000, 3'b111, 1'b0, 1'b1);
        checks++; if (outs !== 3'd1 || dv() !== 3'b001) begin failures++; $display("FAIL prio_tail got=%0d/%b exp=1/001", outs, dv()); end
        drive(3'b000, 3'b111, 1'b0, 1'b0);
        checks++; if (outs !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL prio_end got=%0d/%b exp=0/0", outs, err); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            h_i[i] = '0;
            h_i[i].a_source = 8'(16 + i);
            h_i[i].a_address = 32'h100 * (i + 1);
            h_i[i].a_data = 32'hA000_0000 + i;
        end
        d_i = '0;
        d_i.d_data = 32'h1234_5678;
        test_reset();
        test_round_robin();
        test_full();
        test_hold();
        test_reset_mid();
        test_err();
        test_prio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
